// File: rtl/fifo_rd_unpack.sv
// Read-side unpacker: drains a FWFT FIFO and streams each wide word as RATIO narrow slices.
// Define FIFO_RD_UNPACK_MSB_FIRST_EN to emit the most-significant slice first.
module fifo_rd_unpack #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  head,
    input  logic             empty,
    output logic             pop,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if ((IN_W % OUT_W) != 0) begin : g_bad_ratio
        $error("fifo_rd_unpack: IN_W must be an integer multiple of OUT_W");
    end

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic loaded;
    logic xfer;
    logic done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

    assign loaded    = (state_q == HOLD);
    assign out_valid = loaded;
    assign busy      = loaded;
    assign out_last  = loaded && (idx_q == LAST_IDX);
    assign xfer      = out_valid && out_ready;
    assign done      = xfer && out_last;

    // Flush outranks both the slice advance and the reload.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        pop     = 1'b0;

        if (!rst && !empty && !flush && (!loaded || done)) begin
            pop = 1'b1;
        end

        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (pop) begin
            state_d = HOLD;
            buf_d   = head;
            idx_d   = '0;
        end else if (done) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
`ifdef FIFO_RD_UNPACK_MSB_FIRST_EN
                out_data = buf_q[IN_W-1-i*OUT_W -: OUT_W];
`else
                out_data = buf_q[i*OUT_W +: OUT_W];
`endif
            end
        end
    end

endmodule

// File: doc/fifo_rd_unpack.md
# fifo_rd_unpack

Single-clock read-side unpacker that drains a first-word-fall-through FIFO (head/empty/pop) and emits each wide word as RATIO narrow slices on a valid/ready stream. It sits on the read clock domain directly after a dual-clock FIFO. It turns wide FIFO words into a narrow, back-pressurable item stream at full throughput.

## Interface
- IN_W, 32, width of FIFO head word.
- OUT_W, 8, width of output slice; IN_W must be an integer multiple of OUT_W, elaboration error otherwise.
- RATIO, IN_W/OUT_W (localparam), slices per word; RATIO=1 is legal (pass-through with register stage).
- IDX_W, max(1, $clog2(RATIO)) (localparam), slice index width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- head  in  IN_W  FWFT FIFO output word, valid whenever empty=0.
- empty  in  1  FIFO empty.
- pop  out  1  FIFO read strobe, combinational.
- flush  in  1  synchronous; discard remaining slices of the held word.
- out_data  out  OUT_W  current slice, driven from registers only.
- out_valid  out  1  slice valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  current slice is the final slice of its word.
- busy  out  1  a word is held (loaded=1).

## Operation
- State: word register buf[IN_W], flag loaded, slice index idx[IDX_W].
- Two states: IDLE (loaded=0) and HOLD (loaded=1).
- out_valid = loaded; out_last = loaded && idx==RATIO-1; busy = loaded.
- out_data = buf slice selected by idx; slice order per Configuration.
- xfer = out_valid && out_ready; done = xfer && out_last.
- pop = !rst && !empty && !flush && (!loaded || done). pop is never asserted while empty=1.
- On pop: buf<=head, loaded<=1, idx<=0. This allows a back-to-back reload in the cycle the final slice is accepted.
- On xfer && !out_last: idx<=idx+1.
- On done && !pop: loaded<=0, idx<=0.
- flush=1 (priority over xfer/pop): loaded<=0, idx<=0, and no pop in that cycle. The held word is dropped; FIFO contents are untouched.
- idx never exceeds RATIO-1; there is no wrap beyond the last slice.
- When out_valid=1 and out_ready=0, out_data/out_last/out_valid stay stable until accepted or flushed.

## Timing
- Reset values: loaded=0, idx=0, buf=0, out_valid=0, out_last=0, busy=0, out_data=0, pop=0.
- Latency: empty falls in cycle n with IDLE → pop in cycle n → out_valid=1 in cycle n+1 with slice 0.
- Throughput: one slice per cycle while out_ready=1 and FIFO non-empty. There are no bubbles between words: RATIO words yield RATIO*RATIO consecutive valid cycles.
- Simultaneous done and empty=1: return to IDLE; out_valid=0 in the next cycle.
- Simultaneous done and flush: flush wins; no pop; IDLE in the next cycle.
- Reset asserted mid-word: all state clears immediately (asynchronous) and pop drops within the same cycle. Remaining slices are lost; the FIFO word already popped is not re-read.
- Reset deassertion: the first pop can occur in the first clk edge cycle after rst=0.

## Configuration
- FIFO_RD_UNPACK_MSB_FIRST_EN defined: slice idx = buf[IN_W-1-idx*OUT_W -: OUT_W]. The most-significant slice is emitted first.
- Undefined (default): slice idx = buf[idx*OUT_W +: OUT_W]. The least-significant slice is emitted first, matching the FIFO's native narrow-read order.
- All other behaviour is identical in both builds.

## Test plan
- Reset/idle (IN_W=32, OUT_W=8): rst=1 with empty=0 → pop=0, out_valid=0, out_data=0; release rst → pop=1 in the first cycle.
- Single word: head=0x44332211, empty=0 for one pop, out_ready=1 → out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, out_last only on 0x44, then out_valid=0. With MSB_FIRST_EN the order is 0x44,0x33,0x22,0x11.
- Back-to-back: FIFO holds 0x44332211 then 0x88776655, out_ready=1 → 8 consecutive valid slices 0x11..0x88. The second pop coincides with the 0x44 accept.
- Backpressure: toggle out_ready 1,0,0,1… → out_data holds stable while out_ready=0, no slice is skipped or duplicated, and pop is asserted only on the final-slice accept.
- Flush: flush=1 after 0x22 is accepted → out_valid=0 next cycle and no pop that cycle. The next FIFO word then starts at slice 0.
- Async reset mid-word: assert rst between clk edges after 0x11 is accepted → outputs clear immediately without a clk edge, pop=0, and the next word starts at slice 0 after release.
